// File: rtl/divide768_arbiter.sv
// -----------------------------------------------------------------------------
// divide768_arbiter
//
// Round-robin scheduler sharing one fixed-latency divide-by-768 pipeline among
// N_REQ requesters. Each issued operation pushes its requester index into an
// in-order tag FIFO. Each returning quotient pops a tag and is steered back to
// the requester that issued it. Grants stop while TAG_DEPTH operations are in
// flight.
//
// Optional feature macro: DIV768_ARB_GRANT_CNT_EN
//   defined   : per-requester 16-bit saturating grant counters on grant_cnt
//   undefined : grant_cnt tied to zero
//
// Ports
//   clk_p                 in   clock, rising edge
//   rst_n                 in   asynchronous reset, active low
//   req_dividend          in   packed signed dividends, slice i = requester i
//   req_valid_n           in   per-requester request, active low
//   req_grant             out  one-hot/zero grant, combinational
//   div_dividend          out  dividend to divider, registered
//   div_valid_n           out  divider valid, registered, active low
//   div_quotient          in   quotient from divider
//   div_quotient_valid_n  in   quotient valid from divider, active low
//   rsp_quotient          out  shared response bus, registered
//   rsp_valid_n           out  per-requester response valid, active low
//   inflight              out  tag FIFO occupancy
//   err_orphan            out  sticky: quotient returned with empty tag FIFO
//   grant_cnt             out  per-requester grant counters, 16 bits each
// -----------------------------------------------------------------------------
module divide768_arbiter #(
    parameter int N_REQ        = 4,
    parameter int INPUT_WIDTH  = 18,
    parameter int OUTPUT_WIDTH = 9,
    parameter int TAG_DEPTH    = 32
) (
    input  logic                          clk_p,
    input  logic                          rst_n,
    input  logic [N_REQ*INPUT_WIDTH-1:0]  req_dividend,
    input  logic [N_REQ-1:0]              req_valid_n,
    output logic [N_REQ-1:0]              req_grant,
    output logic [INPUT_WIDTH-1:0]        div_dividend,
    output logic                          div_valid_n,
    input  logic [OUTPUT_WIDTH-1:0]       div_quotient,
    input  logic                          div_quotient_valid_n,
    output logic [OUTPUT_WIDTH-1:0]       rsp_quotient,
    output logic [N_REQ-1:0]              rsp_valid_n,
    output logic [$clog2(TAG_DEPTH):0]    inflight,
    output logic                          err_orphan,
    output logic [N_REQ*16-1:0]           grant_cnt
);

    localparam int TW = $clog2(N_REQ);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(TAG_DEPTH);
    localparam logic [TW-1:0] LAST = TW'(N_REQ - 1);

    logic [TW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]           win;
    logic                    win_vld;
    logic [TW:0]             scan_sum;
    logic [TW-1:0]           scan_idx;
    logic [INPUT_WIDTH-1:0]  sel_dividend;

    logic [TW-1:0]           tag_mem [TAG_DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic                    push, pop, orphan_hit;
    logic [TW-1:0]           head_tag;

    logic [INPUT_WIDTH-1:0]  div_dividend_q;
    logic                    div_valid_n_q;
    logic [OUTPUT_WIDTH-1:0] rsp_quotient_q;
    logic [N_REQ-1:0]        rsp_valid_n_q, rsp_valid_n_d;
    logic                    err_orphan_q;

    // Round-robin scan starting at rr_ptr_q. The index is reduced mod N_REQ
    // by a single conditional subtract so N_REQ need not be a power of two.
    // Only registered occupancy gates the grant, so a same-cycle pop at full
    // does not open a slot until the next cycle.
    always_comb begin
        win      = '0;
        win_vld  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (TW+1)'(k);
            if (scan_sum >= (TW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (TW+1)'(N_REQ);
            end
            scan_idx = scan_sum[TW-1:0];
            if (!win_vld && !req_valid_n[scan_idx]) begin
                win     = scan_idx;
                win_vld = 1'b1;
            end
        end
        if (inflight_q >= FULL) begin
            win_vld = 1'b0;
        end
    end

    always_comb begin
        req_grant    = '0;
        sel_dividend = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_grant[i] = win_vld && (win == TW'(i));
            if (win == TW'(i)) begin
                sel_dividend = req_dividend[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (win_vld) begin
            rr_ptr_d = (win == LAST) ? '0 : win + 1'b1;
        end
    end

    assign push       = win_vld;
    assign pop        = !div_quotient_valid_n && (inflight_q != '0);
    assign orphan_hit = !div_quotient_valid_n && (inflight_q == '0);
    assign head_tag   = tag_mem[rd_ptr_q];

    always_comb begin
        inflight_d = inflight_q;
        case ({push, pop})
            2'b10:   inflight_d = inflight_q + CW'(1);
            2'b01:   inflight_d = inflight_q - CW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        rsp_valid_n_d = '1;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_valid_n_d[i] = !(pop && (head_tag == TW'(i)));
        end
    end

    // Tag storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk_p) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= win;
        end
    end

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= '0;
            div_dividend_q <= '0;
            div_valid_n_q  <= 1'b1;
            rsp_quotient_q <= '0;
            rsp_valid_n_q  <= '1;
            err_orphan_q   <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            div_valid_n_q <= !push;
            rsp_valid_n_q <= rsp_valid_n_d;
            if (push) begin
                wr_ptr_q       <= wr_ptr_q + 1'b1;
                div_dividend_q <= sel_dividend;
            end
            if (pop) begin
                rd_ptr_q       <= rd_ptr_q + 1'b1;
                rsp_quotient_q <= div_quotient;
            end
            if (orphan_hit) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

`ifdef DIV768_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt_q [N_REQ];

    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_grant[i] && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[16*i +: 16] = grant_cnt_q[i];
        end
    end
`else
    assign grant_cnt = '0;
`endif

    assign div_dividend = div_dividend_q;
    assign div_valid_n  = div_valid_n_q;
    assign rsp_quotient = rsp_quotient_q;
    assign rsp_valid_n  = rsp_valid_n_q;
    assign inflight     = inflight_q;
    assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_divide768_arbiter.sv
// -----------------------------------------------------------------------------
// tb_divide768_arbiter
//
// Testbench for divide768_arbiter with default parameters. A behavioural
// divider (3-cycle pipeline) can be swapped for manual quotient injection.
// A reference model at each falling edge predicts grants, occupancy, the
// orphan flag and grant counters, and queues expected responses.
// -----------------------------------------------------------------------------
module tb_divide768_arbiter;

    localparam int N   = 4;
    localparam int IW  = 18;
    localparam int OW  = 9;
    localparam int TD  = 32;
    localparam int PIPE = 3;

    logic              clk_p = 1'b0;
    logic              rst_n;
    logic [N*IW-1:0]   req_dividend;
    logic [N-1:0]      req_valid_n;
    logic [N-1:0]      req_grant;
    logic [IW-1:0]     div_dividend;
    logic              div_valid_n;
    logic [OW-1:0]     div_quotient;
    logic              div_quotient_valid_n;
    logic [OW-1:0]     rsp_quotient;
    logic [N-1:0]      rsp_valid_n;
    logic [5:0]        inflight;
    logic              err_orphan;
    logic [N*16-1:0]   grant_cnt;

    divide768_arbiter #(
        .N_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TAG_DEPTH(TD)
    ) dut (
        .clk_p(clk_p),
        .rst_n(rst_n),
        .req_dividend(req_dividend),
        .req_valid_n(req_valid_n),
        .req_grant(req_grant),
        .div_dividend(div_dividend),
        .div_valid_n(div_valid_n),
        .div_quotient(div_quotient),
        .div_quotient_valid_n(div_quotient_valid_n),
        .rsp_quotient(rsp_quotient),
        .rsp_valid_n(rsp_valid_n),
        .inflight(inflight),
        .err_orphan(err_orphan),
        .grant_cnt(grant_cnt)
    );

    always #5 clk_p = ~clk_p;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Divider model: pipeline or manual injection.
    logic                 model_en;
    logic                 inj_vn;
    logic [OW-1:0]        inj_q;
    logic [PIPE-1:0]      pv_n;
    logic signed [OW-1:0] pq [PIPE];

    always @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            pv_n <= '1;
            for (int i = 0; i < PIPE; i++) pq[i] <= '0;
        end else begin
            pv_n  <= {pv_n[PIPE-2:0], div_valid_n};
            pq[0] <= OW'($signed(div_dividend) / 768);
            for (int i = 1; i < PIPE; i++) pq[i] <= pq[i-1];
        end
    end

    assign div_quotient_valid_n = model_en ? pv_n[PIPE-1] : inj_vn;
    assign div_quotient         = model_en ? pq[PIPE-1]   : inj_q;

    // Reference model and scoreboard.
    typedef struct {
        int                   tag;
        logic signed [OW-1:0] q;
    } exp_t;

    exp_t sb[$];
    int   ref_rr, ref_cnt, ref_orph;
    int   gc [N];

    always @(negedge clk_p) begin
        exp_t e;
        logic [N-1:0] eg;
        logic [N*16-1:0] egc;
        int w, idx;
        if (!rst_n) begin
            sb.delete();
            ref_rr = 0; ref_cnt = 0; ref_orph = 0;
            for (int i = 0; i < N; i++) gc[i] = 0;
        end else begin
            if (rsp_valid_n != '1) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {60'd0, rsp_valid_n}, {60'd0, 4'hF});
                end else begin
                    e = sb.pop_front();
                    chk("rsp_tag", {60'd0, rsp_valid_n}, {60'd0, ~(4'b0001 << e.tag)});
                    chk("rsp_q", $signed(rsp_quotient), e.q);
                end
            end
            chk("inflight", inflight, ref_cnt);
            chk("err_orphan", err_orphan, ref_orph);
            egc = '0;
`ifdef DIV768_ARB_GRANT_CNT_EN
            for (int i = 0; i < N; i++) egc[16*i +: 16] = gc[i][15:0];
`endif
            chk("grant_cnt", grant_cnt, egc);

            eg = '0; w = 0;
            if (ref_cnt < TD) begin
                for (int k = 0; k < N; k++) begin
                    idx = (ref_rr + k) % N;
                    if (eg == '0 && !req_valid_n[idx]) begin
                        eg[idx] = 1'b1;
                        w = idx;
                    end
                end
            end
            chk("req_grant", req_grant, eg);

            if (!div_quotient_valid_n) begin
                if (ref_cnt == 0) ref_orph = 1;
                else ref_cnt--;
            end
            if (eg != '0) begin
                e.tag = w;
                e.q   = OW'($signed(req_dividend[w*IW +: IW]) / 768);
                sb.push_back(e);
                ref_rr = (w + 1) % N;
                if (gc[w] < 65535) gc[w]++;
                ref_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk_p);
        #1;
    endtask

    task automatic negw();
        @(negedge clk_p);
    endtask

    task automatic set_dvd(input int i, input int v);
        req_dividend[i*IW +: IW] = IW'(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] vn;
        logic [N-1:0] g;
    } vec_t;

    vec_t tbl [12];
    int   lat, gcount;

    initial begin
        tbl[0]  = '{4'b1111, 4'b0000};
        tbl[1]  = '{4'b1011, 4'b0100};
        tbl[2]  = '{4'b1110, 4'b0001};
        tbl[3]  = '{4'b0000, 4'b0010};
        tbl[4]  = '{4'b0000, 4'b0100};
        tbl[5]  = '{4'b0000, 4'b1000};
        tbl[6]  = '{4'b0000, 4'b0001};
        tbl[7]  = '{4'b1101, 4'b0010};
        tbl[8]  = '{4'b0110, 4'b1000};
        tbl[9]  = '{4'b0110, 4'b0001};
        tbl[10] = '{4'b0111, 4'b1000};
        tbl[11] = '{4'b1111, 4'b0000};

        rst_n        = 1'b0;
        req_valid_n  = '1;
        req_dividend = '0;
        model_en     = 1'b1;
        inj_vn       = 1'b1;
        inj_q        = '0;
        set_dvd(0, 768);
        set_dvd(1, 1536);
        set_dvd(2, -1536);
        set_dvd(3, 3072);
        tick();
        tick();

        chk("rst_div_valid_n", div_valid_n, 1);
        chk("rst_div_dividend", div_dividend, 0);
        chk("rst_rsp_valid_n", rsp_valid_n, 4'hF);
        chk("rst_rsp_quotient", rsp_quotient, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_grant_cnt", grant_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2, exact latency 1 + 3 + 1.
        set_dvd(2, 7680);
        req_valid_n = 4'b1011;
        negw();
        chk("single_grant", req_grant, 4'b0100);
        tick();
        req_valid_n = '1;
        for (lat = 1; lat < 20; lat++) begin
            negw();
            if (rsp_valid_n != '1) break;
            tick();
        end
        chk("single_latency", lat, PIPE + 2);
        chk("single_rsp_valid_n", rsp_valid_n, 4'b1011);
        chk("single_rsp_q", $signed(rsp_quotient), 10);
        tick();
        set_dvd(2, -1536);

        // Arbitration table from a fresh rr pointer.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            req_valid_n = tbl[i].vn;
            negw();
            chk($sformatf("tbl_grant_%0d", i), req_grant, tbl[i].g);
            tick();
        end
        req_valid_n = '1;
        repeat (10) tick();
        chk("tbl_drained", sb.size(), 0);

        // Back-pressure: divider never returns.
        do_reset();
        model_en = 1'b0;
        set_dvd(0, 3840);
        req_valid_n = 4'b1110;
        gcount = 0;
        for (int i = 0; i < 40; i++) begin
            negw();
            if (req_grant[0]) gcount++;
            tick();
        end
        chk("bp_grants", gcount, TD);
        negw();
        chk("bp_full_grant", req_grant, 0);
        chk("bp_full_inflight", inflight, TD);
        tick();
        inj_vn = 1'b0;
        inj_q  = OW'(5);
        negw();
        chk("bp_pop_cycle_grant", req_grant, 0);
        tick();
        inj_vn = 1'b1;
        gcount = 0;
        for (int i = 0; i < 6; i++) begin
            negw();
            if (req_grant[0]) gcount++;
            tick();
        end
        chk("bp_extra_grants", gcount, 1);
        req_valid_n = '1;
        set_dvd(0, 768);

        // Simultaneous push and pop at occupancy 5.
        do_reset();
        set_dvd(1, 2304);
        set_dvd(3, -5376);
        req_valid_n = 4'b1101;
        repeat (5) tick();
        req_valid_n = 4'b0111;
        inj_vn = 1'b0;
        inj_q  = OW'(3);
        negw();
        chk("pp_inflight_before", inflight, 5);
        chk("pp_grant", req_grant, 4'b1000);
        tick();
        inj_vn = 1'b1;
        req_valid_n = '1;
        negw();
        chk("pp_inflight_after", inflight, 5);
        chk("pp_rsp_valid_n", rsp_valid_n, 4'b1101);
        chk("pp_rsp_q", $signed(rsp_quotient), 3);
        tick();

        // Orphan quotient with empty FIFO.
        do_reset();
        inj_vn = 1'b0;
        inj_q  = OW'(9'h055);
        tick();
        inj_vn = 1'b1;
        negw();
        chk("orphan_rsp_valid_n", rsp_valid_n, 4'hF);
        chk("orphan_flag", err_orphan, 1);
        repeat (5) tick();
        chk("orphan_sticky", err_orphan, 1);
        rst_n = 1'b0;
        #1;
        chk("orphan_cleared", err_orphan, 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset with 10 operations in flight.
        set_dvd(1, 768);
        req_valid_n = 4'b1101;
        repeat (10) tick();
        req_valid_n = '1;
        negw();
        chk("mid_inflight", inflight, 10);
        chk("mid_div_valid_n_busy", div_valid_n, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_div_valid_n", div_valid_n, 1);
        chk("mid_rst_div_dividend", div_dividend, 0);
        chk("mid_rst_rsp_valid_n", rsp_valid_n, 4'hF);
        chk("mid_rst_rsp_q", rsp_quotient, 0);
        chk("mid_rst_inflight", inflight, 0);
        chk("mid_rst_err_orphan", err_orphan, 0);
        chk("mid_rst_grant_cnt", grant_cnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_en = 1'b1;
        req_valid_n = 4'b1101;
        repeat (3) tick();
        req_valid_n = '1;
        negw();
`ifdef DIV768_ARB_GRANT_CNT_EN
        chk("cnt_req1_three", grant_cnt[31:16], 3);
`else
        chk("cnt_tied_zero", grant_cnt, 0);
`endif
        repeat (10) tick();
        chk("final_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
